// File: rtl/kasumi_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package kasumi_pkg;

   localparam int ADDR_W_DEF      = 32;
   localparam int DATA_W_DEF      = 32;
   localparam int MAX_D_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port,
// one transaction at a time, with bounded data priority and fetch cancellation.
module mem_port_arbiter
   import kasumi_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_flush,
   output logic                i_ack,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int STRB_W   = DATA_W / 8;
   localparam int STREAK_W = $clog2(MAX_D_BURST + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

   arb_state_t          state_q;
   arb_owner_t          owner_q;
   logic                drop_q;
   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [STRB_W-1:0]   mem_wstrb_q;
   logic                i_ack_q;
   logic [DATA_W-1:0]   i_rdata_q;
   logic                d_ack_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                busy_q;

   logic i_live;
   logic any_req;
   logic fetch_wins;
   logic fetch_cancel;

   // A fetch arriving together with a redirect is stale and never competes.
   assign i_live       = i_req & ~i_flush;
   assign any_req      = i_live | d_req;
   assign fetch_wins   = i_live & (~d_req | (streak_q == STREAK_MAX));
   assign fetch_cancel = i_flush & (owner_q == OWN_I);

   always_comb begin
      streak_d = streak_q;
      if (state_q == IDLE) begin
         if (!i_req || fetch_wins) begin
            streak_d = '0;
         end else if (d_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_I;
         drop_q      <= 1'b0;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         i_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_ack_q     <= 1'b0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         i_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         streak_q <= streak_d;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q   <= ISSUE;
                  busy_q    <= 1'b1;
                  mem_req_q <= 1'b1;
                  drop_q    <= 1'b0;
                  if (fetch_wins) begin
                     owner_q     <= OWN_I;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= i_addr;
                     mem_wdata_q <= '0;
                     mem_wstrb_q <= '0;
                  end else begin
                     owner_q     <= OWN_D;
                     mem_we_q    <= d_we;
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_wstrb_q <= d_we ? d_wstrb : '0;
                  end
               end
            end
            ISSUE: begin
               if (fetch_cancel) begin
                  drop_q <= 1'b1;
               end
               if (mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= WAIT;
               end
            end
            WAIT: begin
               if (fetch_cancel) begin
                  drop_q <= 1'b1;
               end
               if (mem_rvalid) begin
                  state_q <= RESP;
                  if (owner_q == OWN_D) begin
                     d_ack_q <= 1'b1;
                     if (!mem_we_q) begin
                        d_rdata_q <= mem_rdata;
                     end
                  end else if (!(drop_q || i_flush)) begin
                     // The memory still completes a cancelled fetch; only the ack is withheld.
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               drop_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign i_ack     = i_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the shared memory port; one cycle step samples, checks and drives.
module tb_mem_port_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, i_flush, i_ack;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit auto_drive = 1'b0;

   // Memory device behind the arbiter, and the reference copy kept by the model.
   logic [31:0] mem_arr [256];
   logic [31:0] ref_mem [256];
   logic [31:0] mem_resp;
   int rv_left = 0, stall_left = 0, max_stall = 0, max_lat = 0;

   // Transaction-level model of the arbiter.
   bit          m_active, m_accepted, m_responded, m_owner_d, m_drop;
   int          m_streak;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        e_i_ack, e_d_ack;
   logic [31:0] e_i_rdata, e_d_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_addr();
      return $urandom & 32'hFFFF_FFFC;
   endfunction

   task automatic model_reset();
      m_active = 0; m_accepted = 0; m_responded = 0; m_owner_d = 0; m_drop = 0;
      m_streak = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
      e_i_ack = 0; e_d_ack = 0; e_i_rdata = 0; e_d_rdata = 0;
      rv_left = 0; stall_left = 0;
   endtask

   // Advances the model by the inputs that were present in the cycle just ended.
   task automatic model_step();
      bit i_live;
      e_i_ack = 1'b0;
      e_d_ack = 1'b0;
      i_live  = i_req && !i_flush;
      if (!m_active) begin
         if (i_live || d_req) begin
            m_active = 1; m_accepted = 0; m_responded = 0; m_drop = 0;
            m_owner_d = !(i_live && (!d_req || m_streak >= MAXB));
            if (m_owner_d) begin
               m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
               m_streak = i_req ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
            end else begin
               m_we = 0; m_addr = i_addr; m_wdata = 0; m_wstrb = 0;
               m_streak = 0;
            end
         end else if (!i_req) begin
            m_streak = 0;
         end
      end else if (!m_accepted) begin
         if (i_flush && !m_owner_d) m_drop = 1;
         if (mem_gnt) m_accepted = 1;
      end else if (!m_responded) begin
         if (i_flush && !m_owner_d) m_drop = 1;
         if (mem_rvalid) begin
            m_responded = 1;
            if (m_owner_d) begin
               e_d_ack = 1;
               if (m_we) ref_mem[m_addr[9:2]] = merge(ref_mem[m_addr[9:2]], m_wdata, m_wstrb);
               else e_d_rdata = ref_mem[m_addr[9:2]];
            end else if (!m_drop) begin
               e_i_ack = 1;
               e_i_rdata = ref_mem[m_addr[9:2]];
            end
         end
      end else begin
         m_active = 0;
         m_drop = 0;
      end
      chk("busy", busy, m_active);
      chk("mem_req", mem_req, m_active && !m_accepted);
      if (m_active && !m_accepted) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", mem_we, m_we);
         if (m_we) begin
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wstrb", mem_wstrb, m_wstrb);
         end
      end
      chk("i_ack", i_ack, e_i_ack);
      chk("d_ack", d_ack, e_d_ack);
      chk("i_rdata", i_rdata, e_i_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
   endtask

   task automatic mem_drive();
      logic [7:0] widx;
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = $urandom;
      if (rv_left > 0) begin
         rv_left--;
         if (rv_left == 0) begin
            mem_rvalid = 1;
            mem_rdata = mem_resp;
         end
      end else if (mem_req) begin
         if (stall_left > 0) begin
            stall_left--;
         end else begin
            mem_gnt = 1;
            widx = mem_addr[9:2];
            if (mem_we) begin
               mem_arr[widx] = merge(mem_arr[widx], mem_wdata, mem_wstrb);
               mem_resp = $urandom;
            end else begin
               mem_resp = mem_arr[widx];
            end
            rv_left = 1 + int'($urandom_range(0, max_lat));
            stall_left = int'($urandom_range(0, max_stall));
         end
      end
   endtask

   task automatic drive_random();
      i_flush = 0;
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
      if ($urandom_range(0, 11) == 0) begin
         i_flush = 1;
         i_req = 1'($urandom_range(0, 1));
         i_addr = rand_addr();
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
         i_req = 1;
         i_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
         d_req = 1;
         d_we = 1'($urandom_range(0, 1));
         d_addr = rand_addr();
         d_wdata = $urandom;
         d_wstrb = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      model_step();
      mem_drive();
      if (auto_drive) drive_random();
   endtask

   task automatic run_until_ack(input bit want_d, input int budget, output int n, output int nreq);
      bit done;
      n = -1;
      nreq = 0;
      done = 0;
      for (int k = 1; k <= budget && !done; k++) begin
         step();
         if (mem_req) nreq++;
         if (want_d ? d_ack : i_ack) begin
            n = k;
            done = 1;
         end
      end
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_mem_req"}, mem_req, 0);
      chk({pfx, "_mem_we"}, mem_we, 0);
      chk({pfx, "_mem_addr"}, mem_addr, 0);
      chk({pfx, "_mem_wdata"}, mem_wdata, 0);
      chk({pfx, "_mem_wstrb"}, mem_wstrb, 0);
      chk({pfx, "_i_ack"}, i_ack, 0);
      chk({pfx, "_i_rdata"}, i_rdata, 0);
      chk({pfx, "_d_ack"}, d_ack, 0);
      chk({pfx, "_d_rdata"}, d_rdata, 0);
      chk({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      int n, nreq, dacks, first_i;
      int gseq[$];
      int exp_seq[6];
      logic [31:0] fa, da;
      bit prev_req;

      rst_n = 0;
      i_req = 0; i_addr = 0; i_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      for (int w = 0; w < 256; w++) begin
         mem_arr[w] = $urandom;
         ref_mem[w] = mem_arr[w];
      end
      mem_arr[64]  = 32'h0000_0013; ref_mem[64]  = 32'h0000_0013;
      mem_arr[0]   = 32'h1122_3344; ref_mem[0]   = 32'h1122_3344;
      mem_arr[128] = 32'hA5A5_0200; ref_mem[128] = 32'hA5A5_0200;
      mem_arr[16]  = 32'h0BAD_0040; ref_mem[16]  = 32'h0BAD_0040;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      rst_n = 1;
      step();

      // Fetch only, zero wait.
      i_req = 1; i_addr = 32'h100;
      run_until_ack(1'b0, 20, n, nreq);
      i_req = 0;
      chk("fetch_lat", n, 3);
      chk("fetch_data", i_rdata, 32'h0000_0013);
      step();

      // Data write with the grant held off for two cycles.
      stall_left = 2;
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      run_until_ack(1'b1, 20, n, nreq);
      d_req = 0; d_we = 0;
      chk("write_lat", n, 5);
      chk("write_req_cycles", nreq, 3);
      chk("write_merge", mem_arr[0], 32'h1122_BEEF);
      step();

      // Contention with both requesters held continuously.
      exp_seq = '{1, 1, 1, 1, 0, 1};
      fa = 32'h1000; da = 32'h3000;
      i_req = 1; i_addr = fa; d_req = 1; d_we = 0; d_addr = da;
      dacks = 0; first_i = -1; prev_req = 0;
      for (int k = 0; k < 80 && gseq.size() < 6; k++) begin
         step();
         if (mem_req && !prev_req) gseq.push_back((mem_addr[13:12] == 2'h3) ? 1 : 0);
         prev_req = mem_req;
         if (d_ack) begin dacks++; da += 4; d_addr = da; end
         if (i_ack) begin
            if (first_i < 0) first_i = dacks;
            fa += 4; i_addr = fa;
         end
      end
      i_req = 0; d_req = 0;
      chk("grant_count", gseq.size(), 6);
      for (int g = 0; g < 6 && g < gseq.size(); g++) chk($sformatf("grant_%0d", g), gseq[g], exp_seq[g]);
      chk("dacks_before_iack", first_i, 4);
      repeat (10) step();

      // Flush coinciding with the fetch response.
      i_req = 1; i_addr = 32'h180;
      step();
      step();
      i_flush = 1; i_req = 0;
      step();
      chk("flush_noack", i_ack, 0);
      i_flush = 0;
      step();
      chk("flush_idle", busy, 0);
      i_req = 1; i_addr = 32'h200;
      run_until_ack(1'b0, 20, n, nreq);
      i_req = 0;
      chk("refetch_lat", n, 3);
      chk("refetch_data", i_rdata, 32'hA5A5_0200);
      step();

      // Reset while a data read waits on memory.
      d_req = 1; d_we = 0; d_addr = 32'h80;
      step();
      step();
      rst_n = 0;
      #1;
      check_all_zero("midrst");
      d_req = 0; mem_gnt = 0; mem_rvalid = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      step();
      d_req = 1; d_we = 0; d_addr = 32'h40;
      run_until_ack(1'b1, 20, n, nreq);
      d_req = 0;
      chk("post_rst_lat", n, 3);
      chk("post_rst_data", d_rdata, 32'h0BAD_0040);
      step();

      // Randomized traffic with stalls and variable memory latency.
      max_stall = 3; max_lat = 3;
      auto_drive = 1;
      repeat (3000) step();
      auto_drive = 0;
      i_req = 0; d_req = 0; i_flush = 0;
      repeat (20) step();
      chk("drain_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
